// File: rtl/array_allocator_pkg.sv
// Shared types and constants for the array allocator / free-list manager.
// Optional live-bitmap checking is enabled by defining ARRAY_ALLOCATOR_CHECK_EN.
package array_allocator_pkg;

    localparam int unsigned IndexWidth = 12;

    typedef logic [IndexWidth-1:0] index_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    localparam logic OP_ALLOC = 1'b0;
    localparam logic OP_FREE  = 1'b1;

endpackage

// File: rtl/array_allocator_arbiter.sv
// Two-way round-robin arbiter; the priority pointer only moves when a grant is issued.
module array_allocator_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic prio_q;

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        if (enable) begin
            if (req_valid == 2'b11) begin
                grant_idx = prio_q;
            end else begin
                grant_idx = req_valid[1];
            end
            if (|req_valid) begin
                grant = grant_idx ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (|grant) begin
            prio_q <= ~grant_idx;
        end
    end

endmodule

// File: rtl/array_allocator.sv
// Array allocator: LIFO reuse of freed arrays, then fresh indices, shared by two requesters.
// Defining ARRAY_ALLOCATOR_CHECK_EN adds a live bitmap that rejects frees of non-live arrays.
module array_allocator
    import array_allocator_pkg::*;
#(
    parameter int unsigned NArrays            = 4,
    parameter int unsigned MemoryElementWidth = IndexWidth
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_free,
    input  logic [MemoryElementWidth-1:0] req_array0,
    input  logic [MemoryElementWidth-1:0] req_array1,
    output logic [1:0]                    req_ready,
    output logic [1:0]                    resp_valid,
    output logic                          resp_ok,
    output logic [MemoryElementWidth-1:0] resp_array,
    output logic                          size_clear,
    output logic [MemoryElementWidth-1:0] size_index,
    output logic [MemoryElementWidth-1:0] allocs,
    output logic [MemoryElementWidth-1:0] free_count
);

    localparam int unsigned PtrW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam logic [MemoryElementWidth-1:0] Limit = MemoryElementWidth'(NArrays);
    localparam logic [MemoryElementWidth-1:0] One   = MemoryElementWidth'(1);

    state_e                        state_q, state_d;
    logic                          op_q;
    logic                          who_q;
    logic [MemoryElementWidth-1:0] arr_q;
    logic                          ok_q, ok_d;
    logic [MemoryElementWidth-1:0] res_q, res_d;
    logic [MemoryElementWidth-1:0] allocs_q, allocs_d;
    logic [MemoryElementWidth-1:0] fc_q, fc_d;
    logic [MemoryElementWidth-1:0] freed [NArrays];
    logic                          push;
    logic [PtrW-1:0]               top_ptr;
    logic [PtrW-1:0]               push_ptr;
    logic                          live_ok;
    logic [1:0]                    grant;
    logic                          grant_idx;
    logic                          arb_enable;

    // Gated by reset so req_ready is already 0 while reset is held.
    assign arb_enable = (state_q == StIdle) && !reset;

    array_allocator_arbiter u_arbiter (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .enable    (arb_enable),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign top_ptr  = fc_q[PtrW-1:0] - PtrW'(1);
    assign push_ptr = fc_q[PtrW-1:0];

`ifdef ARRAY_ALLOCATOR_CHECK_EN
    logic [NArrays-1:0] live_q, live_d;

    assign live_ok = live_q[arr_q[PtrW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_q <= '0;
        end else begin
            live_q <= live_d;
        end
    end
`else
    assign live_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ok_d     = ok_q;
        res_d    = res_q;
        allocs_d = allocs_q;
        fc_d     = fc_q;
        push     = 1'b0;
`ifdef ARRAY_ALLOCATOR_CHECK_EN
        live_d   = live_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
                ok_d    = 1'b0;
                res_d   = '0;
                if (op_q == OP_ALLOC) begin
                    if (fc_q != '0) begin
                        ok_d  = 1'b1;
                        res_d = freed[top_ptr];
                        fc_d  = fc_q - One;
                    end else if (allocs_q < Limit) begin
                        ok_d     = 1'b1;
                        res_d    = allocs_q;
                        allocs_d = allocs_q + One;
                    end
`ifdef ARRAY_ALLOCATOR_CHECK_EN
                    if (ok_d) begin
                        live_d[res_d[PtrW-1:0]] = 1'b1;
                    end
`endif
                end else if ((arr_q < Limit) && (fc_q != Limit) && live_ok) begin
                    ok_d = 1'b1;
                    push = 1'b1;
                    fc_d = fc_q + One;
`ifdef ARRAY_ALLOCATOR_CHECK_EN
                    live_d[arr_q[PtrW-1:0]] = 1'b0;
`endif
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OP_ALLOC;
            who_q    <= 1'b0;
            arr_q    <= '0;
            ok_q     <= 1'b0;
            res_q    <= '0;
            allocs_q <= '0;
            fc_q     <= '0;
        end else begin
            state_q  <= state_d;
            ok_q     <= ok_d;
            res_q    <= res_d;
            allocs_q <= allocs_d;
            fc_q     <= fc_d;
            if (|grant) begin
                op_q  <= req_free[grant_idx];
                who_q <= grant_idx;
                arr_q <= grant_idx ? req_array1 : req_array0;
            end
        end
    end

    // Stack contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clock) begin
        if (push) begin
            freed[push_ptr] <= arr_q;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (state_q == StResp) ? {who_q, ~who_q} : 2'b00;
    assign resp_ok    = (state_q == StResp) && ok_q;
    assign resp_array = resp_ok ? res_q : '0;
    assign size_clear = resp_ok && (op_q == OP_ALLOC);
    assign size_index = size_clear ? res_q : '0;
    assign allocs     = allocs_q;
    assign free_count = fc_q;

endmodule

// File: tb/tb_array_allocator.sv
// Directed self-checking bench for array_allocator (honours ARRAY_ALLOCATOR_CHECK_EN).
module tb_array_allocator;
    import array_allocator_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_free;
    index_t     req_array0;
    index_t     req_array1;
    logic [1:0] req_ready;
    logic [1:0] resp_valid;
    logic       resp_ok;
    index_t     resp_array;
    logic       size_clear;
    index_t     size_index;
    index_t     allocs;
    index_t     free_count;

    int checks = 0;
    int errors = 0;

    array_allocator #(
        .NArrays            (4),
        .MemoryElementWidth (12)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_free   (req_free),
        .req_array0 (req_array0),
        .req_array1 (req_array1),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ok    (resp_ok),
        .resp_array (resp_array),
        .size_clear (size_clear),
        .size_index (size_index),
        .allocs     (allocs),
        .free_count (free_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_free   = 2'b00;
        req_array0 = '0;
        req_array1 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Issues one op, returns the response fields and the ready-to-response distance in cycles.
    task automatic run_op(input int who, input logic fr, input index_t arr, output logic ok,
                          output index_t res, output logic sc, output index_t si,
                          output int lat);
        int t;
        req_free[who] = fr;
        if (who == 0) req_array0 = arr;
        else req_array1 = arr;
        req_valid[who] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[who] && t < 20) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (!req_ready[who]) begin
            req_valid[who] = 1'b0;
            ok = 1'b0; res = '0; sc = 1'b0; si = '0; lat = -1;
            return;
        end
        @(negedge clock);
        req_valid[who] = 1'b0;
        #1;
        lat = 1;
        while (!resp_valid[who] && lat < 10) begin
            @(negedge clock);
            #1;
            lat++;
        end
        ok  = resp_ok;
        res = resp_array;
        sc  = size_clear;
        si  = size_index;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = 2'b11;
        req_free  = 2'b00;
        @(negedge clock);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_ok, size_clear} !== 6'b0 || resp_array !== '0 ||
            size_index !== '0 || allocs !== '0 || free_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b ok=%b sc=%b arr=%0d si=%0d al=%0d fc=%0d, want all 0",
                     req_ready, resp_valid, resp_ok, size_clear, resp_array, size_index,
                     allocs, free_count);
        end
        do_reset();
        checks++;
        if (allocs !== '0 || free_count !== '0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: al=%0d fc=%0d ready=%b, want 0 0 00",
                     allocs, free_count, req_ready);
        end
    endtask

    task automatic test_alloc_fresh;
        logic ok, sc;
        index_t res, si;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(0, 1'b0, '0, ok, res, sc, si, lat);
            checks++;
            if (ok !== 1'b1 || res !== index_t'(i) || sc !== 1'b1 || si !== index_t'(i) ||
                lat !== 2) begin
                errors++;
                $display("FAIL alloc_fresh[%0d]: ok=%b res=%0d sc=%b si=%0d lat=%0d, want 1 %0d 1 %0d 2",
                         i, ok, res, sc, si, lat, i, i);
            end
        end
        checks++;
        if (allocs !== 12'd4 || free_count !== 12'd0) begin
            errors++;
            $display("FAIL alloc_fresh_counts: al=%0d fc=%0d, want 4 0", allocs, free_count);
        end
    endtask

    task automatic test_alloc_exhausted;
        logic ok, sc;
        index_t res, si;
        int lat;
        run_op(0, 1'b0, '0, ok, res, sc, si, lat);
        checks++;
        if (ok !== 1'b0 || res !== '0 || sc !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL alloc_exhausted: ok=%b res=%0d sc=%b lat=%0d, want 0 0 0 2",
                     ok, res, sc, lat);
        end
        checks++;
        if (allocs !== 12'd4 || free_count !== 12'd0) begin
            errors++;
            $display("FAIL exhausted_counts: al=%0d fc=%0d, want 4 0", allocs, free_count);
        end
    endtask

    // Stack order, out-of-range free, fill to depth, free when full, pop after full.
    task automatic test_free_lifo;
        logic   ok, sc;
        index_t res, si;
        int     lat;
        int fr_t [11]  = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        int arr_t [11] = '{2, 1, 0, 0, 4, 0, 1, 2, 3, 0, 0};
        int ok_t [11]  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        int res_t [11] = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 3};
        int fc_t [11]  = '{1, 2, 1, 0, 0, 1, 2, 3, 4, 4, 3};
        for (int i = 0; i < 11; i++) begin
            run_op(1, fr_t[i][0], index_t'(arr_t[i]), ok, res, sc, si, lat);
            checks++;
            if (ok !== ok_t[i][0] || res !== index_t'(res_t[i]) ||
                sc !== (ok_t[i][0] & ~fr_t[i][0]) || free_count !== index_t'(fc_t[i]) ||
                allocs !== 12'd4) begin
                errors++;
                $display("FAIL free_lifo[%0d]: ok=%b res=%0d sc=%b fc=%0d al=%0d, want %0d %0d %0d %0d 4",
                         i, ok, res, sc, free_count, allocs, ok_t[i], res_t[i],
                         ok_t[i] & ~fr_t[i], fc_t[i]);
            end
        end
    endtask

    task automatic test_double_free;
        logic   ok, sc;
        index_t res, si;
        int     lat;
        logic   exp_ok;
        index_t exp_fc;
`ifdef ARRAY_ALLOCATOR_CHECK_EN
        exp_ok = 1'b0;
        exp_fc = 12'd1;
`else
        exp_ok = 1'b1;
        exp_fc = 12'd2;
`endif
        do_reset();
        run_op(0, 1'b0, '0, ok, res, sc, si, lat);
        checks++;
        if (ok !== 1'b1 || res !== '0) begin
            errors++;
            $display("FAIL dfree_alloc: ok=%b res=%0d, want 1 0", ok, res);
        end
        run_op(0, 1'b1, '0, ok, res, sc, si, lat);
        checks++;
        if (ok !== 1'b1 || free_count !== 12'd1) begin
            errors++;
            $display("FAIL dfree_first: ok=%b fc=%0d, want 1 1", ok, free_count);
        end
        run_op(0, 1'b1, '0, ok, res, sc, si, lat);
        checks++;
        if (ok !== exp_ok || free_count !== exp_fc || sc !== 1'b0) begin
            errors++;
            $display("FAIL dfree_second: ok=%b fc=%0d sc=%b, want %b %0d 0",
                     ok, free_count, sc, exp_ok, exp_fc);
        end
    endtask

    task automatic test_back_to_back;
        int g_cyc [4], g_idx [4], r_cyc [4], r_idx [4], r_arr [4];
        int n_g = 0, n_r = 0;
        logic onehot_ok = 1'b1;
        do_reset();
        req_free  = 2'b00;
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready == 2'b11) onehot_ok = 1'b0;
            if (req_ready != 2'b00 && n_g < 4) begin
                g_cyc[n_g] = c;
                g_idx[n_g] = int'(req_ready[1]);
                n_g++;
            end
            if (resp_valid != 2'b00 && n_r < 4) begin
                r_cyc[n_r] = c;
                r_idx[n_r] = int'(resp_valid[1]);
                r_arr[n_r] = int'(resp_array);
                n_r++;
            end
            if (c == 11) req_valid = 2'b00;
            @(negedge clock);
            #1;
        end
        checks++;
        if (n_g !== 4 || n_r !== 4 || onehot_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_counts: grants=%0d resps=%0d onehot=%b, want 4 4 1",
                     n_g, n_r, onehot_ok);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (g_idx[k] !== k % 2 || r_idx[k] !== k % 2 || r_cyc[k] !== g_cyc[k] + 2 ||
                    r_arr[k] !== k) begin
                    errors++;
                    $display("FAIL b2b[%0d]: grant=%0d resp_to=%0d gap=%0d arr=%0d, want %0d %0d 2 %0d",
                             k, g_idx[k], r_idx[k], r_cyc[k] - g_cyc[k], r_arr[k],
                             k % 2, k % 2, k);
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        logic   ok, sc;
        index_t res, si;
        int     lat;
        int     t;
        logic   saw_resp = 1'b0;
        do_reset();
        run_op(0, 1'b0, '0, ok, res, sc, si, lat);
        run_op(0, 1'b0, '0, ok, res, sc, si, lat);
        checks++;
        if (allocs !== 12'd2) begin
            errors++;
            $display("FAIL rmid_pre: al=%0d, want 2", allocs);
        end
        req_free[0]  = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[0] && t < 20) begin
            @(negedge clock);
            #1;
            t++;
        end
        @(negedge clock);
        req_valid[0] = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (allocs !== '0 || free_count !== '0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmid_async: al=%0d fc=%0d rv=%b ready=%b, want 0 0 00 00",
                     allocs, free_count, resp_valid, req_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (resp_valid != 2'b00) saw_resp = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (saw_resp !== 1'b0 || allocs !== '0) begin
            errors++;
            $display("FAIL rmid_lost: saw_resp=%b al=%0d, want 0 0", saw_resp, allocs);
        end
        run_op(0, 1'b0, '0, ok, res, sc, si, lat);
        checks++;
        if (ok !== 1'b1 || res !== '0 || allocs !== 12'd1) begin
            errors++;
            $display("FAIL rmid_realloc: ok=%b res=%0d al=%0d, want 1 0 1", ok, res, allocs);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_fresh();
        test_alloc_exhausted();
        test_free_lifo();
        test_double_free();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
